val2_shift_unit: RTL and testbench
==================================

Name: val2_shift_unit

Overview:
Parametrised, multi-cycle successor to the combinational operand-2 generator in the execute stage. Produces Val2 and shifter carry-out for immediate-rotate, immediate-shift, register-specified shift, RRX and memory-offset pass-through. Shifts iteratively, at most STEP bits per cycle, behind valid/ready handshakes on both sides, so a full barrel shifter is not needed on the execute critical path.

Parameters:
WIDTH, 32, datapath width in bits; must be even and at least 16.
STEP, 4, maximum bits shifted per cycle; must be a power of two no greater than WIDTH.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  request valid.
in_ready  output  1  unit can accept; high only in IDLE.
mode  input  3  0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX, 5 IMM_ROT, 6 PASS, 7 reserved (treated as PASS).
operand  input  WIDTH  Val_Rm value.
amount  input  8  shift amount (imm5 zero-extended or Rs[7:0]).
imm12  input  12  immediate field for IMM_ROT and PASS.
carry_in  input  1  current C flag.
out_valid  output  1  result valid; high only in DONE.
out_ready  input  1  consumer accepts result.
val2  output  WIDTH  result.
carry_out  output  1  shifter carry.

Behaviour:
- States: IDLE, SHIFT, DONE. Reset from any state, including mid-SHIFT or DONE, returns to IDLE next edge; val2=0, carry_out=0, out_valid=0, in_ready=1. The pending request is discarded.
- Accept: in_valid && in_ready at an edge latches all inputs and computes count n:
  - LSL, LSR: n = amount if amount <= WIDTH. If amount > WIDTH: result 0, carry 0, n=0.
  - ASR: n = min(amount, WIDTH).
  - ROR: amount=0 gives n=0. amount a nonzero multiple of WIDTH: result=operand, carry=operand[WIDTH-1], n=0. Otherwise n = amount mod WIDTH.
  - RRX: n=0. Result {carry_in, operand[WIDTH-1:1]}, carry=operand[0].
  - IMM_ROT: source = imm12[7:0] zero-extended to WIDTH; n = 2*imm12[11:8] mod WIDTH.
  - PASS and reserved: result = imm12 zero-extended, n=0.
- If n=0, go directly to DONE. Otherwise go to SHIFT with the working register = source and remaining = n.
- SHIFT: each edge shifts by k=min(STEP, remaining) and decrements remaining by k. Fill bits: LSL and LSR fill with 0; ASR fills with the sign bit; ROR and IMM_ROT rotate right. Carry register = last bit shifted out. When remaining reaches 0, go to DONE.
- Latency: out_valid is high after exactly 1+ceil(n/STEP) edges, counting the accept edge.
- Carry when n=0:
  - LSL, LSR, ASR with amount=0: carry_in.
  - ROR with amount=0: carry_in.
  - IMM_ROT with rot=0: carry_in.
  - PASS: carry_in.
  - Special cases above use their listed carry.
- Carry when n>0 equals the ARM shifter carry:
  - LSL: operand[WIDTH-n].
  - LSR, ROR: operand[n-1].
  - ASR: operand[n-1]; when clamped, operand[WIDTH-1].
  - IMM_ROT: result[WIDTH-1].
- DONE: val2 and carry_out are held stable while out_ready=0. On out_valid && out_ready, go to IDLE next edge. There is no same-cycle re-accept, so the minimum initiation interval is 2+ceil(n/STEP) cycles.
- in_valid is ignored outside IDLE. Inputs are don't-care after the accept edge.
- val2 and carry_out are registered. Between results they keep their last value.

Test Plan:
- LSL, operand 0x8000_0001, amount 5, carry_in 0 -> val2 0x0000_0020, carry 0, out_valid 3 edges after accept.
- ASR, operand 0x8000_00F0, amount 40 -> val2 0xFFFF_FFFF, carry 1, 9 edges. Then LSR amount 33 -> val2 0, carry 0, 1 edge.
- IMM_ROT, imm12 0x4FF -> val2 0xFF00_0000, carry 1, 3 edges. Then PASS imm12 0xABC, carry_in 1 -> val2 0x0000_0ABC, carry 1.
- RRX, operand 0x0000_0003, carry_in 1 -> val2 0x8000_0001, carry 1. Then ROR amount 64 on 0x8000_0000 -> val2 unchanged, carry 1, 1 edge.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> val2 stable, in_ready=0, no second accept. A new accept occurs only after the out_ready handshake plus one edge.
- Assert rst for one cycle mid-SHIFT (LSL amount 20) -> next cycle IDLE, in_ready=1, out_valid=0, val2=0, carry_out=0. No stale result appears afterwards.

Source files
------------

// File: rtl/val2_shift_unit.sv
// val2_shift_unit: iterative operand-2 generator for the execute stage.
// Shifts at most STEP bits per cycle behind valid/ready handshakes.
module val2_shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] operand,
    input  logic [7:0]       amount,
    input  logic [11:0]      imm12,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] val2,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] M_LSL = 3'd0;
    localparam logic [2:0] M_LSR = 3'd1;
    localparam logic [2:0] M_ASR = 3'd2;
    localparam logic [2:0] M_ROR = 3'd3;
    localparam logic [2:0] M_RRX = 3'd4;
    localparam logic [2:0] M_IMM = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] val2_q, val2_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [2:0]       mode_q, mode_d;
    logic             cw_q, cw_d;
    logic             carry_q, carry_d;

    logic [WIDTH-1:0] acc_src;
    logic [WIDTH-1:0] acc_res;
    logic             acc_c;
    logic [CW-1:0]    acc_n;
    logic [31:0]      amt_w;
    logic [31:0]      ror_n;
    logic [31:0]      rot_n;

    logic [CW-1:0]    k;
    logic [WIDTH-1:0] sh_res;
    logic             sh_c;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign val2      = val2_q;
    assign carry_out = carry_q;

    // Decode a request into a shift source and count, or a ready result
    always_comb begin
        amt_w   = {24'd0, amount};
        ror_n   = amt_w % 32'(WIDTH);
        rot_n   = {27'd0, imm12[11:8], 1'b0} % 32'(WIDTH);
        acc_src = operand;
        acc_res = operand;
        acc_c   = carry_in;
        acc_n   = '0;
        case (mode)
            M_LSL, M_LSR: begin
                if (amt_w > 32'(WIDTH)) begin
                    acc_res = '0;
                    acc_c   = 1'b0;
                end else begin
                    acc_n = CW'(amt_w);
                end
            end
            M_ASR: begin
                if (amt_w > 32'(WIDTH)) begin
                    acc_n = CW'(WIDTH);
                end else begin
                    acc_n = CW'(amt_w);
                end
            end
            M_ROR: begin
                if (amt_w != 32'd0 && ror_n == 32'd0) begin
                    acc_c = operand[WIDTH-1];
                end else begin
                    acc_n = CW'(ror_n);
                end
            end
            M_RRX: begin
                acc_res = {carry_in, operand[WIDTH-1:1]};
                acc_c   = operand[0];
            end
            M_IMM: begin
                acc_src = WIDTH'(imm12[7:0]);
                acc_res = WIDTH'(imm12[7:0]);
                acc_n   = CW'(rot_n);
            end
            default: begin
                acc_res = WIDTH'(imm12);
            end
        endcase
    end

    // One iteration: shift the working value by up to STEP bits
    always_comb begin
        k      = (rem_q < CW'(STEP)) ? rem_q : CW'(STEP);
        sh_res = work_q;
        sh_c   = cw_q;
        for (int i = 1; i <= STEP; i++) begin
            if (k == CW'(i)) begin
                case (mode_q)
                    M_LSL: begin
                        sh_res = work_q << i;
                        sh_c   = work_q[WIDTH-i];
                    end
                    M_LSR: begin
                        sh_res = work_q >> i;
                        sh_c   = work_q[i-1];
                    end
                    M_ASR: begin
                        sh_res = WIDTH'($signed(work_q) >>> i);
                        sh_c   = work_q[i-1];
                    end
                    default: begin
                        sh_res = (work_q >> i)
                               | (work_q << (WIDTH - i));
                        sh_c   = work_q[i-1];
                    end
                endcase
            end
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        cw_d    = cw_q;
        val2_d  = val2_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mode_d = mode;
                    if (acc_n == '0) begin
                        val2_d  = acc_res;
                        carry_d = acc_c;
                        state_d = DONE;
                    end else begin
                        work_d  = acc_src;
                        rem_d   = acc_n;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = sh_res;
                cw_d   = sh_c;
                rem_d  = rem_q - k;
                if (rem_q == k) begin
                    val2_d  = sh_res;
                    carry_d = sh_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            mode_q  <= '0;
            cw_q    <= 1'b0;
            val2_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            cw_q    <= cw_d;
            val2_q  <= val2_d;
            carry_q <= carry_d;
        end
    end

endmodule

// File: tb/tb_val2_shift_unit.sv
// tb_val2_shift_unit: directed self-checking bench for val2_shift_unit.
// Checks results, carries, latency, backpressure and reset.
module tb_val2_shift_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  mode;
    logic [31:0] operand;
    logic [7:0]  amount;
    logic [11:0] imm12;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] val2;
    logic        carry_out;

    int checks;
    int failures;
    int edges;

    val2_shift_unit #(.WIDTH(32), .STEP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .operand   (operand),
        .amount    (amount),
        .imm12     (imm12),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .val2      (val2),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request from IDLE; count edges until out_valid
    task automatic issue(input logic [2:0] m, input logic [31:0] op,
                         input logic [7:0] a, input logic [11:0] im,
                         input logic ci);
        mode     = m;
        operand  = op;
        amount   = a;
        imm12    = im;
        carry_in = ci;
        in_valid = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        in_valid = 1'b0;
        operand  = 32'hDEAD_BEEF;
        amount   = 8'hA5;
        carry_in = ~ci;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic expect_res(input string nm, input logic [31:0] ev,
                              input logic ec, input int ee);
        checks++;
        if (val2 !== ev) begin
            failures++;
            $display("FAIL %s_val2 got=%h exp=%h", nm, val2, ev);
        end
        checks++;
        if (carry_out !== ec) begin
            failures++;
            $display("FAIL %s_carry got=%b exp=%b", nm, carry_out, ec);
        end
        checks++;
        if (edges != ee || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_latency got=%0d exp=%0d", nm, edges, ee);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode      = 3'd0;
        operand   = 32'd0;
        amount    = 8'd0;
        imm12     = 12'd0;
        carry_in  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (val2 !== 32'd0 || carry_out !== 1'b0) begin
            failures++;
            $display("FAIL rst_outputs got=%h/%b exp=0/0", val2, carry_out);
        end
    endtask

    task automatic test_shifts();
        issue(3'd0, 32'h8000_0001, 8'd5, 12'd0, 1'b0);
        expect_res("lsl5", 32'h0000_0020, 1'b0, 3);
        consume();
        issue(3'd2, 32'h8000_00F0, 8'd40, 12'd0, 1'b0);
        expect_res("asr40", 32'hFFFF_FFFF, 1'b1, 9);
        consume();
        issue(3'd1, 32'hFFFF_FFFF, 8'd33, 12'd0, 1'b1);
        expect_res("lsr33", 32'h0000_0000, 1'b0, 1);
        consume();
        issue(3'd1, 32'h0000_00F8, 8'd4, 12'd0, 1'b0);
        expect_res("lsr4", 32'h0000_000F, 1'b1, 2);
        consume();
        issue(3'd0, 32'h0000_0001, 8'd32, 12'd0, 1'b0);
        expect_res("lsl32", 32'h0000_0000, 1'b1, 9);
        consume();
        issue(3'd2, 32'h1234_5678, 8'd0, 12'd0, 1'b1);
        expect_res("asr0", 32'h1234_5678, 1'b1, 1);
        consume();
        issue(3'd3, 32'h0000_00F0, 8'd7, 12'd0, 1'b0);
        expect_res("ror7", 32'hE000_0001, 1'b1, 3);
        consume();
    endtask

    task automatic test_imm_pass();
        issue(3'd5, 32'd0, 8'd0, 12'h4FF, 1'b0);
        expect_res("immrot", 32'hFF00_0000, 1'b1, 3);
        consume();
        issue(3'd6, 32'd0, 8'd0, 12'hABC, 1'b1);
        expect_res("pass", 32'h0000_0ABC, 1'b1, 1);
        consume();
        issue(3'd7, 32'd0, 8'd0, 12'h5A5, 1'b0);
        expect_res("rsvd", 32'h0000_05A5, 1'b0, 1);
        consume();
    endtask

    task automatic test_rrx_ror();
        issue(3'd4, 32'h0000_0003, 8'd0, 12'd0, 1'b1);
        expect_res("rrx", 32'h8000_0001, 1'b1, 1);
        consume();
        issue(3'd3, 32'h8000_0000, 8'd64, 12'd0, 1'b0);
        expect_res("ror64", 32'h8000_0000, 1'b1, 1);
        consume();
    endtask

    task automatic test_back_to_back();
        issue(3'd0, 32'h8000_0001, 8'd5, 12'd0, 1'b0);
        expect_res("bp_first", 32'h0000_0020, 1'b0, 3);
        mode     = 3'd6;
        imm12    = 12'h123;
        carry_in = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (val2 !== 32'h20 || out_valid !== 1'b1
                || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got=%h/%b/%b exp=20/1/0",
                         c, val2, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1
            || val2 !== 32'h20) begin
            failures++;
            $display("FAIL bp_release got=%b/%b/%h exp=0/1/20",
                     out_valid, in_ready, val2);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || val2 !== 32'h123
            || carry_out !== 1'b1) begin
            failures++;
            $display("FAIL bp_second got=%b/%h/%b exp=1/123/1",
                     out_valid, val2, carry_out);
        end
        consume();
    endtask

    task automatic test_reset_mid_shift();
        logic seen;
        mode     = 3'd0;
        operand  = 32'hFFFF_FFFF;
        amount   = 8'd20;
        carry_in = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_hs got=%b/%b exp=1/0",
                     in_ready, out_valid);
        end
        checks++;
        if (val2 !== 32'd0 || carry_out !== 1'b0) begin
            failures++;
            $display("FAIL midrst_out got=%h/%b exp=0/0",
                     val2, carry_out);
        end
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL midrst_stale got=1 exp=0");
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        edges    = 0;
        rst      = 1'b1;
        test_reset();
        test_shifts();
        test_imm_pass();
        test_rrx_ror();
        test_back_to_back();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
